// File: rtl/aes_pkg.sv
// Shared AES key-schedule types and helpers: FSM states, round constants, GF(2^8) doubling.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, EMIT, SUB, MIX} state_t;

  localparam logic [7:0] AES_RCON_INIT  = 8'h01;
  localparam int         NUM_ROUNDS_128 = 10;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] m);
    logic [7:0] r, s;
    r = 8'h00;
    s = x;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) r = r ^ s;
      s = xtime(s);
    end
    return r;
  endfunction

  logic [7:0] p, inv;

  // inv = a^254 = product of a^(2^i) for i=1..7; zero maps to zero
  always_comb begin
    p   = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p   = gmul(p, p);
      inv = gmul(inv, p);
    end
    y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
        {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128 key schedule; one shared S-box does SubWord a byte per cycle,
// round keys leave on a valid/ready stream.
module aes_key_expand_seq
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         rk_last,
  output logic         busy
);

  state_t      state, state_nx;
  logic [31:0] w0, w1, w2, w3, tmp;
  logic [31:0] rot, t, n0, n1, n2, n3;
  logic [7:0]  rcon, sb_in, sb_out;
  logic [3:0]  round;
  logic [1:0]  byte_cnt;
  logic        last_rk;

  assign last_rk   = (round == 4'(NUM_ROUNDS));
  assign key_ready = (state == IDLE);
  assign rk_valid  = (state == EMIT);
  assign busy      = (state != IDLE);
  assign rk_out    = {w0, w1, w2, w3};
  assign rk_idx    = round;
  assign rk_last   = rk_valid && last_rk;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (key_valid) state_nx = EMIT;
      EMIT:    if (rk_ready) state_nx = last_rk ? IDLE : SUB;
      SUB:     if (byte_cnt == 2'd3) state_nx = MIX;
      MIX:     state_nx = EMIT;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // RotWord(w3), MSB byte first, feeds the shared S-box
  assign rot = {w3[23:0], w3[31:24]};
  always_comb begin
    sb_in = rot[31:24];
    case (byte_cnt)
      2'd0: sb_in = rot[31:24];
      2'd1: sb_in = rot[23:16];
      2'd2: sb_in = rot[15:8];
      2'd3: sb_in = rot[7:0];
      default: sb_in = rot[31:24];
    endcase
  end

  aes_sbox u_sbox (.a(sb_in), .y(sb_out));

  assign t  = tmp ^ {rcon, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  // tmp fills by shifting left, so after four bytes it holds SubWord(RotWord(w3))
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w0       <= '0;
      w1       <= '0;
      w2       <= '0;
      w3       <= '0;
      tmp      <= '0;
      rcon     <= AES_RCON_INIT;
      round    <= '0;
      byte_cnt <= '0;
    end else if (!flush) begin
      case (state)
        IDLE: if (key_valid) begin
          {w0, w1, w2, w3} <= key_in;
          round            <= '0;
          rcon             <= AES_RCON_INIT;
        end
        EMIT: if (rk_ready && !last_rk) byte_cnt <= '0;
        SUB: begin
          tmp      <= {tmp[23:0], sb_out};
          byte_cnt <= byte_cnt + 2'd1;
        end
        MIX: begin
          {w0, w1, w2, w3} <= {n0, n1, n2, n3};
          round            <= round + 4'd1;
          rcon             <= xtime(rcon);
        end
        default: ;
      endcase
    end
  end

endmodule
